// File: rtl/layer_argmax.sv
`default_nettype none
// ============================================================================
// layer_argmax : buffers one N-element Q8.8 layer vector, applies optional
//                ReLU, then finds the argmax serially (one compare per clock).
// Revision     : 1.0 - initial release
// ============================================================================
module layer_argmax #(
    parameter int WIDTH = 16,
    parameter int N     = 2,
    parameter int RELU  = 1,
    parameter int IDXW  = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] in [0:N-1],
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDXW-1:0]         out_idx,
    output logic signed [WIDTH-1:0] out_max
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_buf [0:N-1];
    logic signed [WIDTH-1:0] r_best_val;
    logic [IDXW-1:0]         r_best_idx;
    logic [IDXW-1:0]         r_cnt;
    logic signed [WIDTH-1:0] w_cand;

    function automatic logic signed [WIDTH-1:0] act(input logic signed [WIDTH-1:0] x);
        return ((RELU != 0) && x[WIDTH-1]) ? '0 : x;
    endfunction

    assign w_cand = act(r_buf[r_cnt]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) r_buf[i] <= in[i];
                        r_best_val <= act(in[0]);
                        r_best_idx <= '0;
                        r_cnt      <= IDXW'(1);
                        r_state    <= (N > 1) ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    // strict compare so ties keep the earlier index
                    if (w_cand > r_best_val) begin
                        r_best_val <= w_cand;
                        r_best_idx <= r_cnt;
                    end
                    r_cnt <= r_cnt + IDXW'(1);
                    if (r_cnt == LAST_IDX) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_idx   = r_best_idx;
    assign out_max   = r_best_val;

endmodule
`default_nettype wire

// File: tb/tb_layer_argmax.sv
`default_nettype none
// ============================================================================
// tb_layer_argmax : scoreboard bench for layer_argmax (N=2 ReLU, N=2 raw, N=4 raw)
// Revision        : 1.0 - initial release
// ============================================================================
module tb_layer_argmax;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic signed [W-1:0] in1 [0:1];
    logic signed [W-1:0] in0 [0:1];
    logic signed [W-1:0] in4 [0:3];
    logic v1, ir1, ov1, or1;
    logic v0, ir0, ov0, or0;
    logic v4, ir4, ov4, or4;
    logic [0:0] idx1, idx0;
    logic [1:0] idx4;
    logic signed [W-1:0] max1, max0, max4;

    layer_argmax #(.WIDTH(W), .N(2), .RELU(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(v1), .in_ready(ir1),
        .out_valid(ov1), .out_ready(or1), .out_idx(idx1), .out_max(max1));
    layer_argmax #(.WIDTH(W), .N(2), .RELU(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in(in0), .in_valid(v0), .in_ready(ir0),
        .out_valid(ov0), .out_ready(or0), .out_idx(idx0), .out_max(max0));
    layer_argmax #(.WIDTH(W), .N(4), .RELU(0)) d4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .in_valid(v4), .in_ready(ir4),
        .out_valid(ov4), .out_ready(or4), .out_idx(idx4), .out_max(max4));

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] val;
    } exp_t;

    exp_t q1[$], q0[$], q4[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic exp_t mk(input int i, input int v);
        exp_t e;
        e.idx = 2'(i);
        e.val = W'(v);
        return e;
    endfunction

    task automatic zero_inputs();
        for (int i = 0; i < 2; i++) begin in1[i] = '0; in0[i] = '0; end
        for (int i = 0; i < 4; i++) in4[i] = '0;
        v1 = 1'b0; v0 = 1'b0; v4 = 1'b0;
    endtask

    // Present a vector to one instance for one edge, then scramble the inputs.
    task automatic send(input int which, input int a0, input int a1, input int a2, input int a3);
        case (which)
            1: begin in1[0] = W'(a0); in1[1] = W'(a1); v1 = 1'b1; end
            0: begin in0[0] = W'(a0); in0[1] = W'(a1); v0 = 1'b1; end
            default: begin
                in4[0] = W'(a0); in4[1] = W'(a1); in4[2] = W'(a2); in4[3] = W'(a3);
                v4 = 1'b1;
            end
        endcase
        @(posedge clk); #1;
        zero_inputs();
    endtask

    task automatic wait_valid(input int which, output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if ((which == 1 && ov1 === 1'b1) || (which == 0 && ov0 === 1'b1) ||
                (which == 4 && ov4 === 1'b1)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        or1 = 1'b0; or0 = 1'b0; or4 = 1'b0;
        zero_inputs();
        #12;
        vectors++; if (ir1 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready1: got %b want 1", ir1); end
        vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid1: got %b want 0", ov1); end
        vectors++; if (idx1 !== 1'b0 || max1 !== 16'sd0) begin miscompares++; $display("FAIL reset_outs1: got idx %0d max %0d want 0 0", idx1, max1); end
        vectors++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin miscompares++; $display("FAIL reset_hs4: got rdy %b vld %b want 1 0", ir4, ov4); end
        vectors++; if (idx4 !== 2'd0 || max4 !== 16'sd0) begin miscompares++; $display("FAIL reset_outs4: got idx %0d max %0d want 0 0", idx4, max4); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        or1 = 1'b1;
        q1.push_back(mk(0, 448));
        send(1, 448, -288, 0, 0);
        vectors++; if (ov1 !== 1'b0 || ir1 !== 1'b0) begin miscompares++; $display("FAIL basic_after_capture: got vld %b rdy %b want 0 0", ov1, ir1); end
        wait_valid(1, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL basic_latency: got %0d want 1", lat); end
        e = q1.pop_front();
        vectors++; if ({1'b0, idx1} !== e.idx || max1 !== e.val) begin miscompares++; $display("FAIL basic_result: got idx %0d max %0d want %0d %0d", idx1, max1, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        vectors++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin miscompares++; $display("FAIL basic_return_idle: got vld %b rdy %b want 0 1", ov1, ir1); end
    endtask

    task automatic test_tie();
        int lat;
        exp_t e;
        or1 = 1'b1;
        q1.push_back(mk(0, 256));
        send(1, 256, 256, 0, 0);
        wait_valid(1, lat);
        e = q1.pop_front();
        vectors++; if (lat !== 1 || {1'b0, idx1} !== e.idx || max1 !== e.val) begin miscompares++; $display("FAIL tie: got lat %0d idx %0d max %0d want 1 %0d %0d", lat, idx1, max1, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
    endtask

    task automatic test_negative();
        int lat;
        exp_t e;
        or1 = 1'b1; or0 = 1'b1;
        q1.push_back(mk(0, 0));
        send(1, -128, -64, 0, 0);
        wait_valid(1, lat);
        e = q1.pop_front();
        vectors++; if (lat !== 1 || {1'b0, idx1} !== e.idx || max1 !== e.val) begin miscompares++; $display("FAIL neg_relu: got lat %0d idx %0d max %0d want 1 %0d %0d", lat, idx1, max1, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        q0.push_back(mk(1, -64));
        send(0, -128, -64, 0, 0);
        wait_valid(0, lat);
        e = q0.pop_front();
        vectors++; if (lat !== 1 || {1'b0, idx0} !== e.idx || max0 !== e.val) begin miscompares++; $display("FAIL neg_raw: got lat %0d idx %0d max %0d want 1 %0d %0d", lat, idx0, max0, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        vectors++; if (ir0 !== 1'b1 || ov0 !== 1'b0) begin miscompares++; $display("FAIL neg_raw_idle: got rdy %b vld %b want 1 0", ir0, ov0); end
    endtask

    task automatic test_n4();
        int lat;
        exp_t e;
        or4 = 1'b1;
        q4.push_back(mk(2, 32767));
        send(4, -32768, 100, 32767, 32767);
        wait_valid(4, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL n4_latency: got %0d want 3", lat); end
        e = q4.pop_front();
        vectors++; if (idx4 !== e.idx || max4 !== e.val) begin miscompares++; $display("FAIL n4_result: got idx %0d max %0d want %0d %0d", idx4, max4, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        vectors++; if (ir4 !== 1'b1) begin miscompares++; $display("FAIL n4_idle: got rdy %b want 1", ir4); end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        or1 = 1'b0;
        q1.push_back(mk(0, 448));
        send(1, 448, -288, 0, 0);
        wait_valid(1, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int k = 0; k < 5; k++) begin
            in1[0] = 16'sd1000; in1[1] = 16'sd2000;
            v1 = k[0];
            @(posedge clk); #1;
            vectors++; if (ov1 !== 1'b1 || ir1 !== 1'b0 || idx1 !== 1'b0 || max1 !== 16'sd448) begin
                miscompares++; $display("FAIL bp_hold%0d: got vld %b rdy %b idx %0d max %0d want 1 0 0 448", k, ov1, ir1, idx1, max1);
            end
        end
        // out_ready and in_valid together in DONE: only the output handshake completes
        in1[0] = 16'sd1000; in1[1] = 16'sd2000; v1 = 1'b1; or1 = 1'b1;
        e = q1.pop_front();
        vectors++; if ({1'b0, idx1} !== e.idx || max1 !== e.val) begin miscompares++; $display("FAIL bp_result: got idx %0d max %0d want %0d %0d", idx1, max1, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        vectors++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin miscompares++; $display("FAIL bp_no_bypass: got vld %b rdy %b want 0 1", ov1, ir1); end
        q1.push_back(mk(1, 2000));
        @(posedge clk); #1;
        zero_inputs();
        wait_valid(1, lat);
        e = q1.pop_front();
        vectors++; if (lat !== 1 || {1'b0, idx1} !== e.idx || max1 !== e.val) begin miscompares++; $display("FAIL bp_next_vector: got lat %0d idx %0d max %0d want 1 %0d %0d", lat, idx1, max1, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        exp_t e;
        // abort during SCAN with cnt = 2
        or4 = 1'b1;
        q4.push_back(mk(1, 2));
        send(4, 1, 2, 3, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q4.delete();
        #1;
        vectors++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin miscompares++; $display("FAIL abort_scan_hs: got vld %b rdy %b want 0 1", ov4, ir4); end
        vectors++; if (idx4 !== 2'd0 || max4 !== 16'sd0) begin miscompares++; $display("FAIL abort_scan_outs: got idx %0d max %0d want 0 0", idx4, max4); end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ov4 !== 1'b0) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
        q4.push_back(mk(1, 9));
        send(4, 5, 9, 1, 3);
        wait_valid(4, lat);
        e = q4.pop_front();
        vectors++; if (lat !== 3 || idx4 !== e.idx || max4 !== e.val) begin miscompares++; $display("FAIL abort_fresh: got lat %0d idx %0d max %0d want 3 %0d %0d", lat, idx4, max4, e.idx, $signed(e.val)); end
        @(posedge clk); #1;
        // abort while holding a result in DONE
        or1 = 1'b0;
        send(1, 300, 100, 0, 0);
        wait_valid(1, lat);
        rst_n = 1'b0;
        #1;
        vectors++; if (ov1 !== 1'b0 || ir1 !== 1'b1 || max1 !== 16'sd0) begin miscompares++; $display("FAIL abort_done: got vld %b rdy %b max %0d want 0 1 0", ov1, ir1, max1); end
        #2;
        rst_n = 1'b1;
        or1 = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_negative();
        test_n4();
        test_backpressure();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_argmax.md
# layer_argmax

Downstream classifier stage for the Q8.8 `linearLayer`/`neuron` array. It captures one parallel vector of N signed layer outputs through a valid/ready handshake and applies an optional ReLU. It then scans the buffered elements serially, one comparison per clock, and presents the winning index and its activated value through a second valid/ready handshake. This lets a purely combinational layer drive a registered, back-pressurable result interface without a wide N-way comparator tree.

## Interface
- WIDTH, 16, element bit-width (Q8.8 signed)
- N, 2, number of layer outputs consumed (N ≥ 1)
- RELU, 1, 1: clamp negative elements to 0 before comparison and reporting; 0: raw signed compare
- IDXW, ($clog2(N) > 0 ? $clog2(N) : 1), index width (derived, not overridden)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  signed [WIDTH-1:0] [0:N-1]  layer output vector (unpacked array, element 0 = neuron 0)
- in_valid  input  1  `in` holds a valid vector
- in_ready  output  1  block can accept a vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_idx  output  [IDXW-1:0]  index of maximum element
- out_max  output  signed [WIDTH-1:0]  activated value of maximum element

## Operation
- The block has one clock and one reset. Reset is asynchronous and active-low.
- act(x) = (RELU && x < 0) ? 0 : x. Comparisons are full-width signed. There is no arithmetic growth and no saturation.
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid && in_ready`, all N elements are copied into an internal buffer.
    - best_val ← act(in[0]), best_idx ← 0, cnt ← 1.
    - Next state is SCAN if N > 1, otherwise DONE.
  - SCAN: each cycle compares act(buf[cnt]) against best_val.
    - Strictly greater replaces best_val and best_idx. Ties keep the lower index.
    - cnt increments. After evaluating cnt = N-1, the FSM moves to DONE.
  - DONE: `out_valid` = 1, and `out_idx`/`out_max` drive best_idx/best_val, held stable. On `out_valid && out_ready`, the FSM returns to IDLE.
- `in_ready` = (state == IDLE). This is combinational from state only and never depends on `in_valid`.
- `in_valid` outside IDLE is ignored. Upstream holds its vector until `in_ready`.
- After capture, `in` may change freely. The result depends only on the buffered copy.
- There is no accept-while-DONE bypass. A new vector is accepted only in IDLE.
- `out_idx`/`out_max` are don't-care while `out_valid` = 0, but must equal best_idx/best_val registers (no X).

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_idx` 0, `out_max` 0, buffer 0, cnt 0.
- Latency: `out_valid` rises N-1 clock edges after the capture edge (0 for N = 1, 1 for N = 2).
- Result hold: values are stable every cycle `out_valid` is high until the `out_ready` handshake edge. `out_valid` drops on the cycle after that edge.
- Throughput: one vector per N+1 cycles at best (capture, N-1 scan, DONE handshake).
- Back-pressure: `out_ready` low holds DONE indefinitely, with `in_ready` low throughout.
- Reset mid-operation (SCAN or DONE) aborts immediately:
  - The scan is discarded and `out_valid` drops asynchronously.
  - The FSM returns to IDLE with no result emitted for the aborted vector.
- Simultaneous `out_ready` and `in_valid` in DONE: only the output handshake completes. The input is accepted on a later IDLE cycle.

## Test plan
- N=2, RELU=1, in={448,-288} (1.75, -1.125 Q8.8), out_ready=1 → one cycle after capture: out_valid=1, out_idx=0, out_max=448. in_ready returns to 1 the cycle after the handshake.
- N=2, in={256,256} → out_idx=0, out_max=256 (tie keeps the lower index).
- N=2, in={-128,-64}:
  - RELU=1 → out_idx=0, out_max=0.
  - RELU=0 → out_idx=1, out_max=-64.
- N=4, RELU=0, in={-32768,100,32767,32767}; change `in` to all zeros right after capture → out_valid 3 edges after capture, out_idx=2, out_max=32767.
- Back-pressure, N=2, in={448,-288}: hold out_ready=0 for 5 cycles while toggling in_valid with new data → out_valid stays 1, out_idx=0 and out_max=448 stay stable, in_ready stays 0, no new capture. Then out_ready=1 → single handshake, IDLE.
- N=4, assert rst_n=0 during SCAN cnt=2 → out_valid=0, in_ready=1, outputs 0 immediately (asynchronously). After release, a fresh vector {5,9,1,3} → out_idx=1, out_max=9.
